// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM scheduler: configuration field codes,
// commit FSM states and the reset period constant.
package pwm_pkg;

    typedef enum logic [1:0] {
        FIELD_PERIOD = 2'd0,
        FIELD_DUTY   = 2'd1,
        FIELD_OFFSET = 2'd2,
        FIELD_ENABLE = 2'd3
    } cfg_field_e;

    typedef enum logic {
        ST_CLEAN = 1'b0,
        ST_DIRTY = 1'b1
    } commit_state_e;

    // All ones; truncated to WIDTH bits this is the longest period, 2^WIDTH-1.
    localparam logic [31:0] RESET_PERIOD = 32'hFFFF_FFFF;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: phase-shifts the shared counter by its offset and
// registers the comparison against its duty value.
module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_duty,
    input  logic [WIDTH-1:0] i_offset,
    input  logic             i_enable,
    output logic             o_out
);

    logic [WIDTH:0] w_cntX;
    logic [WIDTH:0] w_periodX;
    logic [WIDTH:0] w_offsetX;
    logic [WIDTH:0] w_dutyX;
    logic [WIDTH:0] w_phase;
    logic           w_inRange;
    logic           w_level;
    logic           r_out;

    assign w_cntX    = {1'b0, i_cnt};
    assign w_periodX = {1'b0, i_period};
    assign w_offsetX = {1'b0, i_offset};
    assign w_dutyX   = {1'b0, i_duty};

    // One extra bit keeps cnt + period + 1 from overflowing before the offset is removed.
    assign w_inRange = (w_offsetX <= w_periodX);
    assign w_phase   = (w_cntX >= w_offsetX) ? (w_cntX - w_offsetX)
                                             : (w_cntX + w_periodX + 1'b1 - w_offsetX);
    assign w_level   = i_enable && w_inRange && (w_phase < w_dutyX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_level;
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/pwm_scheduler.sv
// Multi-channel PWM generator sharing one period counter, with shadow/active
// configuration registers committed atomically at the period boundary.
module pwm_scheduler
    import pwm_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 8,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [1:0]          cfg_field,
    input  logic [WIDTH-1:0]    cfg_data,
    output logic [CHANNELS-1:0] out,
    output logic                wrap,
    output logic                pending
);

    localparam logic [WIDTH-1:0] RST_PERIOD = RESET_PERIOD[WIDTH-1:0];

    commit_state_e r_state;
    commit_state_e w_stateNext;

    logic [WIDTH-1:0]    r_cnt;
    logic                r_wrap;
    logic [WIDTH-1:0]    r_periodSh;
    logic [WIDTH-1:0]    r_periodAct;
    logic [WIDTH-1:0]    r_dutySh    [CHANNELS];
    logic [WIDTH-1:0]    r_dutyAct   [CHANNELS];
    logic [WIDTH-1:0]    r_offsetSh  [CHANNELS];
    logic [WIDTH-1:0]    r_offsetAct [CHANNELS];
    logic [CHANNELS-1:0] r_enableSh;
    logic [CHANNELS-1:0] r_enableAct;
    logic [CHANNELS-1:0] w_out;

    logic w_atEnd;
    logic w_commit;
    logic w_accept;

    // Writes are refused only on the commit edge so no write can slip past the copy.
    assign w_atEnd   = (r_cnt == r_periodAct);
    assign w_commit  = (r_state == ST_DIRTY) && w_atEnd;
    assign cfg_ready = !w_commit;
    assign w_accept  = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_CLEAN: if (w_accept) w_stateNext = ST_DIRTY;
            ST_DIRTY: if (w_commit) w_stateNext = ST_CLEAN;
            default:  w_stateNext = ST_CLEAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_atEnd ? '0 : r_cnt + 1'b1;
            r_wrap <= w_atEnd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_periodSh <= RST_PERIOD;
            r_enableSh <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_dutySh[i]   <= '0;
                r_offsetSh[i] <= '0;
            end
        end else if (w_accept) begin
            case (cfg_field_e'(cfg_field))
                FIELD_PERIOD: r_periodSh           <= cfg_data;
                FIELD_DUTY:   r_dutySh[cfg_chan]   <= cfg_data;
                FIELD_OFFSET: r_offsetSh[cfg_chan] <= cfg_data;
                FIELD_ENABLE: r_enableSh[cfg_chan] <= cfg_data[0];
                default:      ;
            endcase
        end
    end

    // The active set only changes on the last count, so new values start at cnt=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_periodAct <= RST_PERIOD;
            r_enableAct <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_dutyAct[i]   <= '0;
                r_offsetAct[i] <= '0;
            end
        end else if (w_commit) begin
            r_periodAct <= r_periodSh;
            r_enableAct <= r_enableSh;
            r_dutyAct   <= r_dutySh;
            r_offsetAct <= r_offsetSh;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .i_cnt    (r_cnt),
            .i_period (r_periodAct),
            .i_duty   (r_dutyAct[g]),
            .i_offset (r_offsetAct[g]),
            .i_enable (r_enableAct[g]),
            .o_out    (w_out[g])
        );
    end

    assign out     = w_out;
    assign wrap    = r_wrap;
    assign pending = (r_state == ST_DIRTY);

endmodule

// File: doc/pwm_scheduler.md
PWM_SCHEDULER -- requirements
Module: pwm_scheduler

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, the number of PWM outputs sharing one period counter.
REQ-002 SHALL have parameter WIDTH, default 8, the bit width of the period, duty and offset fields.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port cfg_valid, input, 1 bit: a configuration write is offered.
REQ-006 SHALL have port cfg_ready, output, 1 bit: the block accepts the write this cycle.
REQ-007 SHALL have port cfg_chan, input, clog2(CHANNELS) bits: the target channel (ignored for the period field).
REQ-008 SHALL have port cfg_field, input, 2 bits: 0=period (global), 1=duty, 2=offset, 3=enable (cfg_data[0]).
REQ-009 SHALL have port cfg_data, input, WIDTH bits: the write data.
REQ-010 SHALL have port out, output, CHANNELS bits: the registered PWM outputs.
REQ-011 SHALL have port wrap, output, 1 bit: a one-cycle pulse registered on the cycle after cnt==period_act.
REQ-012 SHALL have port pending, output, 1 bit: high while shadow configuration is uncommitted.

Function
REQ-013 SHALL run a free counter cnt that counts 0..period_act and returns to 0 after the cycle where cnt==period_act; period_act=0 gives wrap every cycle.
REQ-014 SHALL hold two register sets: shadow (written by cfg) and active (used by the datapath): period, and per channel duty, offset and enable.
REQ-015 SHALL transfer a write into shadow on cfg_valid&&cfg_ready; the active set is unaffected.
REQ-016 SHALL implement a commit FSM with states CLEAN and DIRTY: an accepted write goes to DIRTY; on the wrap cycle in DIRTY, shadow is copied to active and the state returns to CLEAN.
REQ-017 SHALL deassert cfg_ready only on the wrap cycle while DIRTY, so no write races the commit; a write accepted on a wrap cycle while CLEAN commits at the next wrap.
REQ-018 SHALL apply committed values from cnt=0 of the next period.
REQ-019 SHALL drive pending equal to (state==DIRTY).
REQ-020 SHALL compute the channel phase as (cnt - offset) mod (period_act+1), evaluated in WIDTH+1 bits without overflow.
REQ-021 SHALL register out[i] from (enable[i] && phase < duty[i]), giving 1 cycle of latency from cnt to out.
REQ-022 SHALL hold out[i] at 0 when duty==0, enable==0 or offset>period_act.
REQ-023 SHALL hold out[i] constantly at 1 when duty>period_act and enable==1 and offset<=period_act.
REQ-024 SHALL make identical shadow writes still set DIRTY, and SHALL make the last write to the same field before a commit win.

Reset
REQ-025 SHALL set on rst: cnt=0, state CLEAN, out=0, wrap=0, pending=0, and cfg_ready=1 from the first cycle after reset.
REQ-026 SHALL reset both register sets to period=2^WIDTH-1, and duty=0, offset=0, enable=0 for every channel.
REQ-027 SHALL discard uncommitted shadow writes when rst is asserted mid-period, taking no commit.

Structure
REQ-028 SHALL place the cfg_field encodings (FIELD_PERIOD, FIELD_DUTY, FIELD_OFFSET, FIELD_ENABLE) and the reset period constant in a shared package, pwm_pkg.
REQ-029 SHALL implement the per-channel phase compare and output register as sub-module pwm_channel, instantiated CHANNELS times, with the counter and FSM in the top.

Verification (CHANNELS=4, WIDTH=8)
REQ-030 SHALL cover reset: hold rst for 3 cycles -> out=0, wrap=0, pending=0, cfg_ready=1; wrap first pulses 256 cycles after release.
REQ-031 SHALL cover a basic period: write period=9 and ch0 duty=5, offset=0, enable=1 -> pending=1 until wrap, then out[0] high 5 of every 10 cycles, starting 1 cycle after cnt=0.
REQ-032 SHALL cover phase offset: ch1 duty=5, offset=5, enable=1 with ch0 as in REQ-031 -> out[0]&out[1] never high, and out[0]|out[1] always high.
REQ-033 SHALL cover the commit race: keep cfg_valid high across a wrap while DIRTY -> cfg_ready=0 on exactly that cycle, the write is accepted the next cycle, and pending is reasserted.
REQ-034 SHALL cover duty boundaries: with period=9, duty=0 -> out low forever; duty=12 -> out high forever; offset=10 -> out low.
REQ-035 SHALL cover reset mid-period: rst at cnt=4 with DIRTY -> all outputs reset, and the shadow values never appear on out.
